// File: rtl/multi_blink_pkg.sv
// multi_blink shared types.
// Channel modes, burst FSM states and gap length multiplier.
package multi_blink_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PULSE_HI = 2'd0,
    PULSE_LO = 2'd1,
    GAP      = 2'd2
  } burst_st_e;

  localparam int GAP_MULT = 4;

endpackage

// File: rtl/blink_chan.sv
// One LED channel: config registers, counters and BLINK/BURST sequencing.
// Advances only on the shared prescaler tick; a config write wins over a tick.
module blink_chan
  import multi_blink_pkg::*;
#(
  parameter int PBITS = 8,
  parameter int BBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       cfg_mode,
  input  logic [PBITS-1:0] cfg_half,
  input  logic [BBITS-1:0] cfg_burst,
  output logic             led,
  output logic             flg
);

  localparam int GW = PBITS + 2;

  mode_e            mode_q, mode_d, cmode;
  burst_st_e        st_q, st_d;
  logic [PBITS-1:0] half_q, half_d;
  logic [PBITS-1:0] phase_q, phase_d;
  logic [BBITS-1:0] burst_q, burst_d;
  logic [BBITS-1:0] pcnt_q, pcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [GW-1:0]    gap_last;
  logic             led_q, led_d;
  logic             flg_q, flg_d;
  logic             ph_hit, gap_hit, last_pair;

  assign cmode     = mode_e'(cfg_mode);
  assign gap_last  = GW'(GAP_MULT * (int'(half_q) + 1) - 1);
  assign ph_hit    = phase_q == half_q;
  assign gap_hit   = gcnt_q == gap_last;
  assign last_pair = BBITS'(pcnt_q + 1) == burst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= OFF;
      st_q    <= PULSE_HI;
      half_q  <= '0;
      phase_q <= '0;
      burst_q <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      led_q   <= 1'b0;
      flg_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      st_q    <= st_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      burst_q <= burst_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      led_q   <= led_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    st_d    = st_q;
    half_d  = half_q;
    phase_d = phase_q;
    burst_d = burst_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    if (wr) begin
      mode_d  = cmode;
      half_d  = cfg_half;
      burst_d = cfg_burst;
      phase_d = '0;
      pcnt_d  = '0;
      gcnt_d  = '0;
      st_d    = (cfg_burst == '0) ? GAP : PULSE_HI;
    end else if (tick) begin
      unique case (mode_q)
        BLINK: phase_d = ph_hit ? '0 : PBITS'(phase_q + 1);
        BURST: begin
          unique case (st_q)
            PULSE_HI: begin
              phase_d = ph_hit ? '0 : PBITS'(phase_q + 1);
              if (ph_hit) st_d = PULSE_LO;
            end
            PULSE_LO: begin
              phase_d = ph_hit ? '0 : PBITS'(phase_q + 1);
              if (ph_hit) begin
                pcnt_d = BBITS'(pcnt_q + 1);
                st_d   = last_pair ? GAP : PULSE_HI;
              end
            end
            GAP: begin
              gcnt_d = gap_hit ? '0 : GW'(gcnt_q + 1);
              if (gap_hit) begin
                pcnt_d = '0;
                st_d   = (burst_q == '0) ? GAP : PULSE_HI;
              end
            end
            default: st_d = GAP;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = led_q;
    flg_d = 1'b0;
    if (wr) begin
      led_d = (cmode == ON) ||
              (cmode == BURST && cfg_burst != '0);
    end else begin
      unique case (mode_q)
        OFF: led_d = 1'b0;
        ON:  led_d = 1'b1;
        BLINK: begin
          if (tick && ph_hit) begin
            led_d = !led_q;
            flg_d = led_q;
          end
        end
        BURST: begin
          if (tick) begin
            unique case (st_q)
              PULSE_HI: if (ph_hit) led_d = 1'b0;
              PULSE_LO: if (ph_hit) led_d = !last_pair;
              GAP: begin
                if (gap_hit) begin
                  led_d = burst_q != '0;
                  flg_d = 1'b1;
                end
              end
              default: led_d = 1'b0;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign led = led_q;
  assign flg = flg_q;

  a_flg_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    flg_q |=> !flg_q);
  a_flg_mode: assert property (@(posedge clk) disable iff (!rst_n)
    flg_q |-> (mode_q == BLINK || mode_q == BURST));
  a_flg_tick: assert property (@(posedge clk) disable iff (!rst_n)
    flg_q |-> $past(tick));
  a_blink_led: assert property (@(posedge clk) disable iff (!rst_n)
    (mode_q == BLINK && !$past(wr) && led_q != $past(led_q))
      |-> $past(tick));

endmodule

// File: rtl/multi_blink.sv
// Shared prescaler feeding NCH independently configured LED channels.
// Config writes to a channel index outside 0..NCH-1 match no channel.
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int CBITS = 16,
  parameter int NCH   = 4,
  parameter int PBITS = 8,
  parameter int BBITS = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PBITS-1:0] cfg_half,
  input  logic [BBITS-1:0] cfg_burst,
  output logic             tick,
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   flg
);

  logic [CBITS-1:0] cnt;
  logic             tick_i;

  assign tick_i = en && (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_i;
      if (en) cnt <= CBITS'(cnt + 1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (cfg_ch == CHW'(i));

    blink_chan #(
      .PBITS(PBITS),
      .BBITS(BBITS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick_i),
      .wr       (wr),
      .cfg_mode (cfg_mode),
      .cfg_half (cfg_half),
      .cfg_burst(cfg_burst),
      .led      (led[i]),
      .flg      (flg[i])
    );
  end

endmodule

// File: tb/tb_multi_blink.sv
// Self-checking bench for multi_blink with CBITS=2, NCH=3.
// Expected LED levels derive from elapsed ticks since each channel's last write.
module tb_multi_blink;

  localparam int NCH = 3;
  localparam int PB  = 8;
  localparam int BB  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [PB-1:0]  cfg_half = '0;
  logic [BB-1:0]  cfg_burst = '0;
  logic           tick;
  logic [NCH-1:0] led;
  logic [NCH-1:0] flg;

  int checks = 0;
  int errors = 0;

  int md[NCH];
  int hf[NCH];
  int bs[NCH];
  int k[NCH];
  int cnt_m;
  logic tick_m;
  logic [NCH-1:0] flg_m;

  multi_blink #(
    .CBITS(2), .NCH(NCH), .PBITS(PB), .BBITS(BB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half),
    .cfg_burst(cfg_burst),
    .tick(tick), .led(led), .flg(flg)
  );

  always #5 clk = ~clk;

  function automatic int period(int c);
    int h;
    h = hf[c] + 1;
    if (md[c] == 2) return 2 * h;
    if (bs[c] == 0) return 4 * h;
    return (2 * bs[c] + 4) * h;
  endfunction

  function automatic logic [NCH-1:0] led_exp();
    logic [NCH-1:0] v;
    int h, b, slot;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      h = hf[c] + 1;
      b = bs[c];
      case (md[c])
        1: v[c] = 1'b1;
        2: v[c] = ((k[c] / h) % 2) == 1;
        3: begin
          if (b == 0) v[c] = 1'b0;
          else begin
            slot = (k[c] % ((2 * b + 4) * h)) / h;
            v[c] = (slot < 2 * b) && (slot % 2 == 0);
          end
        end
        default: v[c] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      md[c] = 0; hf[c] = 0; bs[c] = 0; k[c] = 0;
    end
    cnt_m = 0;
    tick_m = 1'b0;
    flg_m = '0;
  endtask

  task automatic step();
    logic tp;
    @(posedge clk);
    tp = en && (cnt_m == 3);
    for (int c = 0; c < NCH; c++) begin
      flg_m[c] = 1'b0;
      if (cfg_we && int'(cfg_ch) == c) begin
        md[c] = int'(cfg_mode);
        hf[c] = int'(cfg_half);
        bs[c] = int'(cfg_burst);
        k[c]  = 0;
      end else if (tp && md[c] >= 2) begin
        k[c]++;
        if (k[c] % period(c) == 0) flg_m[c] = 1'b1;
      end
    end
    tick_m = tp;
    if (en) cnt_m = (cnt_m + 1) % 4;
    #1;
  endtask

  task automatic wr(int ch, int mode, int half, int burst);
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_half  = PB'(half);
    cfg_burst = BB'(burst);
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    en = 1'b1;
    #1;
    checks++;
    if (led !== '0 || flg !== '0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_out led=%b flg=%b tick=%b exp 0", led, flg, tick);
    end
    #12 rst_n = 1'b1;
    for (int n = 0; n < 64; n++) begin
      step();
      checks += 3;
      if (led !== '0) begin
        errors++;
        $display("FAIL idle_led act=%b exp=000", led);
      end
      if (flg !== '0) begin
        errors++;
        $display("FAIL idle_flg act=%b exp=000", flg);
      end
      if (tick !== tick_m) begin
        errors++;
        $display("FAIL idle_tick act=%b exp=%b n=%0d", tick, tick_m, n);
      end
    end
  endtask

  task automatic test_blink();
    int pulses;
    pulses = 0;
    wr(0, 2, 1, 0);
    for (int n = 0; n < 48; n++) begin
      step();
      if (flg[0]) pulses++;
      checks += 2;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL blink_led act=%b exp=%b", led, led_exp());
      end
      if (flg !== flg_m) begin
        errors++;
        $display("FAIL blink_flg act=%b exp=%b", flg, flg_m);
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL blink_flg_count act=%0d exp=3", pulses);
    end
  endtask

  task automatic test_burst();
    wr(1, 3, 0, 2);
    for (int n = 0; n < 80; n++) begin
      step();
      checks += 3;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL burst_led act=%b exp=%b n=%0d", led, led_exp(), n);
      end
      if (flg !== flg_m) begin
        errors++;
        $display("FAIL burst_flg act=%b exp=%b n=%0d", flg, flg_m, n);
      end
      if (tick !== tick_m) begin
        errors++;
        $display("FAIL burst_tick act=%b exp=%b", tick, tick_m);
      end
    end
  endtask

  task automatic test_write_on_tick();
    for (int n = 0; n < 8 && cnt_m != 3; n++) step();
    wr(2, 2, 2, 0);
    checks += 3;
    if (flg[2] !== 1'b0) begin
      errors++;
      $display("FAIL wtick_flg act=%b exp=0", flg[2]);
    end
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL wtick_tick act=%b exp=1", tick);
    end
    if (led !== led_exp()) begin
      errors++;
      $display("FAIL wtick_led act=%b exp=%b", led, led_exp());
    end
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++;
      if (led[2] !== (n == 12)) begin
        errors++;
        $display("FAIL wtick_toggle act=%b exp=%b n=%0d", led[2], n == 12, n);
      end
    end
    wr(3, 1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      step();
      checks += 2;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL badch_led act=%b exp=%b", led, led_exp());
      end
      if (flg !== flg_m) begin
        errors++;
        $display("FAIL badch_flg act=%b exp=%b", flg, flg_m);
      end
    end
  endtask

  task automatic test_en_freeze();
    int hi;
    hi = 0;
    wr(0, 2, 3, 0);
    for (int n = 0; n < 40 && !led[0]; n++) step();
    hi = 1;
    for (int n = 0; n < 5; n++) begin
      step();
      if (led[0]) hi++;
    end
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (led[0]) hi++;
      checks += 3;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL freeze_led act=%b exp=%b", led, led_exp());
      end
      if (flg !== '0) begin
        errors++;
        $display("FAIL freeze_flg act=%b exp=000", flg);
      end
      if (tick !== tick_m) begin
        errors++;
        $display("FAIL freeze_tick act=%b exp=%b", tick, tick_m);
      end
    end
    en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL resume_led act=%b exp=%b", led, led_exp());
      end
      if (!led[0]) break;
      hi++;
    end
    checks++;
    if (hi != 26) begin
      errors++;
      $display("FAIL freeze_len act=%0d exp=26", hi);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_half  = PB'($urandom_range(0, 2));
        cfg_burst = BB'($urandom_range(0, 3));
        cfg_we    = 1'b1;
      end
      step();
      cfg_we = 1'b0;
      checks += 3;
      if (led !== led_exp()) begin
        errors++;
        $display("FAIL rand_led act=%b exp=%b n=%0d", led, led_exp(), n);
      end
      if (flg !== flg_m) begin
        errors++;
        $display("FAIL rand_flg act=%b exp=%b n=%0d", flg, flg_m, n);
      end
      if (tick !== tick_m) begin
        errors++;
        $display("FAIL rand_tick act=%b exp=%b n=%0d", tick, tick_m, n);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    wr(1, 3, 1, 3);
    for (int n = 0; n < 3; n++) step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (led !== '0 || flg !== '0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out led=%b flg=%b tick=%b exp 0", led, flg, tick);
    end
    #2 rst_n = 1'b1;
    for (int n = 0; n < 32; n++) begin
      step();
      checks += 3;
      if (led !== '0) begin
        errors++;
        $display("FAIL postrst_led act=%b exp=000", led);
      end
      if (flg !== '0) begin
        errors++;
        $display("FAIL postrst_flg act=%b exp=000", flg);
      end
      if (tick !== tick_m) begin
        errors++;
        $display("FAIL postrst_tick act=%b exp=%b", tick, tick_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_write_on_tick();
    test_en_freeze();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
